// File: rtl/wb_writeback_if.sv
// Writeback stage bundle: MEM/WB pipeline inputs, multi-cycle result handshake,
// stall request and the register-file write port (RegWrite/A3/WD3).
// slave = writeback stage, master = the surrounding pipeline / register file.
interface wb_writeback_if #(
  parameter int DW = 32
);
  logic          mem_valid;
  logic          mem_regwrite;
  logic          mem_memtoreg;
  logic [4:0]    mem_dst;
  logic [DW-1:0] mem_alu;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    mem_ldtype;
  logic          md_valid;
  logic [4:0]    md_dst;
  logic [DW-1:0] md_data;
  logic          md_ready;
  logic          stall_req;
  logic          RegWrite;
  logic [4:0]    A3;
  logic [DW-1:0] WD3;

  modport slave (
    input  mem_valid, mem_regwrite, mem_memtoreg, mem_dst, mem_alu, mem_rdata, mem_ldtype,
    input  md_valid, md_dst, md_data,
    output md_ready, stall_req, RegWrite, A3, WD3
  );

  modport master (
    output mem_valid, mem_regwrite, mem_memtoreg, mem_dst, mem_alu, mem_rdata, mem_ldtype,
    output md_valid, md_dst, md_data,
    input  md_ready, stall_req, RegWrite, A3, WD3
  );
endinterface

// File: rtl/wb_writeback.sv
// Writeback stage: registers the MEM/WB write, aligns loads, and merges multiply/divide
// results through a QDEPTH-entry buffer. Write port is one cycle after MEM sampling.
// Backpressure: md_ready drops when the buffer is full; stall_req holds MEM for one cycle
// after the buffer head has waited STARVE cycles. Optional macro: WB_SUBWORD_LOAD_EN
// enables lb/lbu/lh/lhu extraction (otherwise every load writes the full word).
module wb_writeback #(
  parameter int DW     = 32,
  parameter int QDEPTH = 2,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_writeback_if.slave bus
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = $clog2(STARVE + 1);

  // Buffer storage and pointers
  logic [4:0]    dst_q  [QDEPTH];
  logic [4:0]    dst_d  [QDEPTH];
  logic [DW-1:0] data_q [QDEPTH];
  logic [DW-1:0] data_d [QDEPTH];
  logic [QDEPTH-1:0] live_q, live_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_req_q, stall_req_d;
  // Write port registers
  logic          regwrite_q, regwrite_d;
  logic [4:0]    a3_q, a3_d;
  logic [DW-1:0] wd3_q, wd3_d;

  logic          md_ready;
  logic          pipe_wr;
  logic          head_vld, head_live, pop, push;
  logic [DW-1:0] load_val, pipe_val;

  assign md_ready      = (count_q < CW'(QDEPTH));
  assign bus.md_ready  = md_ready;
  assign bus.stall_req = stall_req_q;
  assign bus.RegWrite  = regwrite_q;
  assign bus.A3        = a3_q;
  assign bus.WD3       = wd3_q;

`ifdef WB_SUBWORD_LOAD_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  // Little-endian byte/halfword extraction with sign or zero extension
  always_comb begin
    ld_byte  = bus.mem_rdata[7:0];
    ld_half  = bus.mem_alu[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_val = bus.mem_rdata;
    case (bus.mem_alu[1:0])
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      2'd3:    ld_byte = bus.mem_rdata[31:24];
      default: ld_byte = bus.mem_rdata[7:0];
    endcase
    case (bus.mem_ldtype)
      3'b001:  load_val = {{(DW-8){ld_byte[7]}}, ld_byte};
      3'b010:  load_val = {{(DW-8){1'b0}}, ld_byte};
      3'b011:  load_val = {{(DW-16){ld_half[15]}}, ld_half};
      3'b100:  load_val = {{(DW-16){1'b0}}, ld_half};
      default: load_val = bus.mem_rdata;
    endcase
  end
`else
  logic unused_ldtype;
  assign unused_ldtype = ^bus.mem_ldtype;
  // Word loads only: the read word passes straight through
  always_comb begin
    load_val = bus.mem_rdata;
  end
`endif

  // Pipeline write qualification and writeback value select
  always_comb begin
    pipe_wr  = ~stall_req_q & bus.mem_valid & bus.mem_regwrite & (bus.mem_dst != 5'd0);
    pipe_val = bus.mem_memtoreg ? load_val : bus.mem_alu;
  end

  // Buffer push/pop/kill, write-port arbitration and starvation tracking
  always_comb begin
    dst_d      = dst_q;
    data_d     = data_q;
    live_d     = live_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    regwrite_d = 1'b0;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    starve_d   = starve_q;

    head_vld  = (count_q != '0);
    head_live = live_q[rd_ptr_q];
    // Killed heads are dropped immediately since they never need the write port.
    pop  = head_vld & (~head_live | ~pipe_wr | stall_req_q);
    push = bus.md_valid & md_ready & (bus.md_dst != 5'd0);

    // A pipeline write supersedes older buffered results for the same register.
    for (int i = 0; i < QDEPTH; i++) begin
      if (pipe_wr && live_q[i] && (dst_q[i] == bus.mem_dst)) live_d[i] = 1'b0;
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + AW'(1);
    end
    // Enqueued after the kill so a same-cycle md result (the newer one) survives.
    if (push) begin
      dst_d[wr_ptr_q]  = bus.md_dst;
      data_d[wr_ptr_q] = bus.md_data;
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (pipe_wr) begin
      regwrite_d = 1'b1;
      a3_d       = bus.mem_dst;
      wd3_d      = pipe_val;
    end else if (pop && head_live) begin
      regwrite_d = 1'b1;
      a3_d       = dst_q[rd_ptr_q];
      wd3_d      = data_q[rd_ptr_q];
    end

    if (pop)                                         starve_d = '0;
    else if (head_vld && (starve_q < SW'(STARVE)))   starve_d = starve_q + SW'(1);
    stall_req_d = ~pop & (starve_d == SW'(STARVE));
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        dst_q[i]  <= '0;
        data_q[i] <= '0;
      end
      live_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      stall_req_q <= 1'b0;
      regwrite_q  <= 1'b0;
      a3_q        <= '0;
      wd3_q       <= '0;
    end else begin
      dst_q       <= dst_d;
      data_q      <= data_d;
      live_q      <= live_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      stall_req_q <= stall_req_d;
      regwrite_q  <= regwrite_d;
      a3_q        <= a3_d;
      wd3_q       <= wd3_d;
    end
  end
endmodule

// File: tb/tb_wb_writeback.sv
// Directed bench for wb_writeback: reset, ALU writes, load alignment, md buffering,
// starvation stall, kill by newer pipeline write, and reset mid-stream.
module tb_wb_writeback;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_writeback_if #(.DW(32)) bus ();

  wb_writeback #(.DW(32), .QDEPTH(2), .STARVE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem(input logic v, input logic rw, input logic m2r, input logic [4:0] dst,
                           input logic [31:0] alu, input logic [31:0] rdata, input logic [2:0] lt);
    bus.mem_valid = v; bus.mem_regwrite = rw; bus.mem_memtoreg = m2r; bus.mem_dst = dst;
    bus.mem_alu = alu; bus.mem_rdata = rdata; bus.mem_ldtype = lt;
  endtask

  task automatic drive_md(input logic v, input logic [4:0] dst, input logic [31:0] data);
    bus.md_valid = v; bus.md_dst = dst; bus.md_data = data;
  endtask

  task automatic idle();
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0);
    drive_md(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    step();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite); end
    checks++; if (bus.A3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d want 0", bus.A3); end
    checks++; if (bus.WD3 !== 32'd0) begin errors++; $display("FAIL reset_wd3: got %h want 0", bus.WD3); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_req); end
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready: got %b want 1", bus.md_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    drive_mem(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 3'd0);
    step();
    checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %b want 1", bus.RegWrite); end
    checks++; if (bus.A3 !== 5'd5) begin errors++; $display("FAIL alu_a3: got %0d want 5", bus.A3); end
    checks++; if (bus.WD3 !== 32'h1234) begin errors++; $display("FAIL alu_wd3: got %h want 00001234", bus.WD3); end
    drive_mem(1'b1, 1'b1, 1'b0, 5'd0, 32'hDEAD, 32'h0, 3'd0);
    step();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL alu_dst0_regwrite: got %b want 0", bus.RegWrite); end
    checks++; if (bus.A3 !== 5'd5) begin errors++; $display("FAIL alu_dst0_a3_hold: got %0d want 5", bus.A3); end
    checks++; if (bus.WD3 !== 32'h1234) begin errors++; $display("FAIL alu_dst0_wd3_hold: got %h want 00001234", bus.WD3); end
    drive_mem(1'b1, 1'b0, 1'b0, 5'd6, 32'hBEEF, 32'h0, 3'd0);
    step();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL alu_norw_regwrite: got %b want 0", bus.RegWrite); end
    drive_mem(1'b0, 1'b1, 1'b0, 5'd6, 32'hBEEF, 32'h0, 3'd0);
    step();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL alu_novalid_regwrite: got %b want 0", bus.RegWrite); end
    idle();
  endtask

  task automatic test_load();
    logic [2:0]  lt_v  [10];
    logic [1:0]  off_v [10];
    logic [31:0] exp_v [10];
    lt_v  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b001, 3'b011, 3'b010, 3'b100, 3'b000, 3'b111};
    off_v = '{2'd3,   2'd3,   2'd2,   2'd2,   2'd1,   2'd3,   2'd2,   2'd0,   2'd1,   2'd3};
`ifdef WB_SUBWORD_LOAD_EN
    exp_v = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F,
              32'hFFFF80FF, 32'h000000FF, 32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};
`else
    exp_v = '{default: 32'h80FF7F01};
`endif
    for (int i = 0; i < 10; i++) begin
      drive_mem(1'b1, 1'b1, 1'b1, 5'(i + 10), {30'h400, off_v[i]}, 32'h80FF7F01, lt_v[i]);
      step();
      checks++; if (bus.WD3 !== exp_v[i]) begin errors++; $display("FAIL load_wd3[%0d]: got %h want %h", i, bus.WD3, exp_v[i]); end
      checks++; if (bus.A3 !== 5'(i + 10)) begin errors++; $display("FAIL load_a3[%0d]: got %0d want %0d", i, bus.A3, i + 10); end
    end
    idle();
  endtask

  task automatic test_starvation();
    drive_mem(1'b1, 1'b1, 1'b0, 5'd1, 32'h101, 32'h0, 3'd0);
    drive_md(1'b1, 5'd7, 32'hAAAA);
    step();
    checks++; if (bus.A3 !== 5'd1) begin errors++; $display("FAIL starve_first_a3: got %0d want 1", bus.A3); end
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL starve_ready_one: got %b want 1", bus.md_ready); end
    drive_mem(1'b1, 1'b1, 1'b0, 5'd2, 32'h102, 32'h0, 3'd0);
    drive_md(1'b1, 5'd8, 32'hBBBB);
    step();
    checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL starve_ready_full: got %b want 0", bus.md_ready); end
    checks++; if (bus.A3 !== 5'd2) begin errors++; $display("FAIL starve_second_a3: got %0d want 2", bus.A3); end
    drive_md(1'b0, 5'd0, 32'h0);
    for (int d = 3; d <= 4; d++) begin
      drive_mem(1'b1, 1'b1, 1'b0, 5'(d), 32'(256 + d), 32'h0, 3'd0);
      step();
      checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_early_stall[%0d]: got %b want 0", d, bus.stall_req); end
    end
    drive_mem(1'b1, 1'b1, 1'b0, 5'd5, 32'h105, 32'h0, 3'd0);
    step();
    checks++; if (bus.stall_req !== 1'b1) begin errors++; $display("FAIL starve_stall_pulse: got %b want 1", bus.stall_req); end
    checks++; if (bus.A3 !== 5'd5) begin errors++; $display("FAIL starve_fifth_a3: got %0d want 5", bus.A3); end
    drive_mem(1'b1, 1'b1, 1'b0, 5'd6, 32'h106, 32'h0, 3'd0);
    step();
    checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL starve_pop_regwrite: got %b want 1", bus.RegWrite); end
    checks++; if (bus.A3 !== 5'd7) begin errors++; $display("FAIL starve_pop_a3: got %0d want 7", bus.A3); end
    checks++; if (bus.WD3 !== 32'hAAAA) begin errors++; $display("FAIL starve_pop_wd3: got %h want 0000aaaa", bus.WD3); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL starve_stall_end: got %b want 0", bus.stall_req); end
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL starve_ready_after_pop: got %b want 1", bus.md_ready); end
    step();
    checks++; if (bus.A3 !== 5'd6 || bus.WD3 !== 32'h106) begin errors++; $display("FAIL starve_held_mem: got a3=%0d wd3=%h want a3=6 wd3=00000106", bus.A3, bus.WD3); end
    idle();
    step();
    checks++; if (bus.A3 !== 5'd8 || bus.WD3 !== 32'hBBBB || bus.RegWrite !== 1'b1) begin errors++; $display("FAIL starve_second_entry: got rw=%b a3=%0d wd3=%h want rw=1 a3=8 wd3=0000bbbb", bus.RegWrite, bus.A3, bus.WD3); end
    step();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL starve_drained: got %b want 0", bus.RegWrite); end
  endtask

  task automatic test_kill();
    drive_md(1'b1, 5'd9, 32'h99);
    step();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL kill_push_regwrite: got %b want 0", bus.RegWrite); end
    drive_md(1'b0, 5'd0, 32'h0);
    drive_mem(1'b1, 1'b1, 1'b0, 5'd9, 32'h55, 32'h0, 3'd0);
    step();
    checks++; if (bus.A3 !== 5'd9 || bus.WD3 !== 32'h55) begin errors++; $display("FAIL kill_pipe_write: got a3=%0d wd3=%h want a3=9 wd3=00000055", bus.A3, bus.WD3); end
    idle();
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL kill_entry_written[%0d]: got rw=%b wd3=%h want rw=0", c, bus.RegWrite, bus.WD3); end
    end
    checks++; if (bus.WD3 !== 32'h55 || bus.md_ready !== 1'b1) begin errors++; $display("FAIL kill_after: got wd3=%h ready=%b want wd3=00000055 ready=1", bus.WD3, bus.md_ready); end
    drive_mem(1'b1, 1'b1, 1'b0, 5'd10, 32'h11, 32'h0, 3'd0);
    drive_md(1'b1, 5'd10, 32'h22);
    step();
    checks++; if (bus.A3 !== 5'd10 || bus.WD3 !== 32'h11) begin errors++; $display("FAIL same_cycle_pipe: got a3=%0d wd3=%h want a3=10 wd3=00000011", bus.A3, bus.WD3); end
    idle();
    step();
    checks++; if (bus.RegWrite !== 1'b1 || bus.A3 !== 5'd10 || bus.WD3 !== 32'h22) begin errors++; $display("FAIL same_cycle_md: got rw=%b a3=%0d wd3=%h want rw=1 a3=10 wd3=00000022", bus.RegWrite, bus.A3, bus.WD3); end
    drive_md(1'b1, 5'd0, 32'h33);
    step();
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL md_dst0_ready: got %b want 1", bus.md_ready); end
    idle();
    step();
    checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL md_dst0_dropped: got %b want 0", bus.RegWrite); end
  endtask

  task automatic test_reset_mid();
    drive_mem(1'b1, 1'b1, 1'b0, 5'd3, 32'h77, 32'h0, 3'd0);
    drive_md(1'b1, 5'd12, 32'hC);
    step();
    drive_mem(1'b1, 1'b1, 1'b0, 5'd4, 32'h78, 32'h0, 3'd0);
    drive_md(1'b1, 5'd13, 32'hD);
    step();
    checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL mid_full_before_reset: got %b want 0", bus.md_ready); end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.RegWrite !== 1'b0 || bus.A3 !== 5'd0 || bus.WD3 !== 32'd0) begin errors++; $display("FAIL mid_reset_port: got rw=%b a3=%0d wd3=%h want all 0", bus.RegWrite, bus.A3, bus.WD3); end
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", bus.md_ready); end
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL mid_reset_stall: got %b want 0", bus.stall_req); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL mid_reset_stale_write[%0d]: got rw=%b a3=%0d want rw=0", c, bus.RegWrite, bus.A3); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_alu();
    test_load();
    test_starvation();
    test_kill();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_writeback.md
# wb_writeback

Writeback stage of the MIPS pipeline: the writer side of the register-file write port. Holds the MEM/WB pipeline register, selects and aligns the writeback value (ALU result or loaded data), and merges results from the multi-cycle multiply/divide unit through a small buffer. It drives the register file's `RegWrite`/`A3`/`WD3`, which the register file samples on the falling clock edge.

## Interface
- `DW`, 32, datapath width
- `QDEPTH`, 2, multi-cycle result buffer entries (power of 2, ≥2)
- `STARVE`, 4, cycles the buffer head may wait before a pipeline stall is requested
- `clk` in 1: clock, rising-edge active
- `rst_n` in 1: asynchronous, active-low reset
- `mem_valid` in 1: MEM stage presents an instruction
- `mem_regwrite` in 1: instruction writes a register
- `mem_memtoreg` in 1: 1 = load data, 0 = ALU result
- `mem_dst` in 5: destination register
- `mem_alu` in DW: ALU result; bits [1:0] are the load byte offset
- `mem_rdata` in DW: data-memory read word
- `mem_ldtype` in 3: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu
- `md_valid` in 1: multi-cycle unit offers a result
- `md_dst` in 5, `md_data` in DW: that result
- `md_ready` out 1: buffer accepts `md_*` this cycle
- `stall_req` out 1: registered; upstream must hold MEM inputs this cycle
- `RegWrite` out 1, `A3` out 5, `WD3` out DW: register-file write port

## Operation
- Pipeline capture: each rising edge with `stall_req`=0, a pipeline write is pending when `mem_valid & mem_regwrite & (mem_dst!=0)`; it is registered onto `RegWrite`=1, `A3`=`mem_dst`, `WD3`=selected value.
- Value select: `mem_memtoreg`=0 → `mem_alu`; =1 → load-aligned `mem_rdata` (little-endian). lb/lbu: byte at offset `mem_alu[1:0]`, sign-/zero-extended. lh/lhu: halfword at `mem_alu[1]`, `mem_alu[0]` ignored. Codes 101–111 treated as lw.
- md buffer: FIFO of QDEPTH {dst,data}. `md_ready` = (count < QDEPTH), combinational from registered count. Push when `md_valid & md_ready`; `md_dst`=0 handshakes but is dropped.
- Arbitration: pipeline has priority. Buffer head is popped onto the write port in any cycle without a pending pipeline write, or in a `stall_req` cycle.
- Kill: a pipeline write whose `mem_dst` matches any valid buffered entry invalidates that entry (the newer pipeline value wins); killed entries are discarded when they reach the head without writing.
- Starvation: counter increments each cycle the head is valid and not popped; reaching STARVE sets `stall_req`=1 for exactly the next cycle, during which the head is popped and MEM inputs are ignored. Counter clears on pop.
- Nothing to write: `RegWrite`=0, and `A3`/`WD3` hold their previous values.

## Timing
- Reset (async, immediate): `RegWrite`=0, `A3`=0, `WD3`=0, `stall_req`=0, buffer empty, starvation counter 0, so `md_ready`=1.
- Latency: MEM inputs sampled at edge N appear on the write port from edge N to edge N+1; the register file writes at the falling edge in between. Buffered md result: ≥1 cycle after push.
- Push and pop in the same cycle are both legal; a full buffer still deasserts `md_ready`, even if a pop happens that cycle.
- Push with a simultaneous pipeline write to the same dst: the entry is enqueued and is not killed (the md result is the newer one).
- Reset mid-operation discards buffered entries; after reset, `md_ready`=1 within the same cycle.

## Configuration
- `WB_SUBWORD_LOAD_EN` defined: lb/lbu/lh/lhu extraction as above.
- Undefined: `mem_ldtype` and `mem_alu[1:0]` ignored for loads; every load writes the full `mem_rdata` (lw only) and the extraction logic is absent.

## Test plan
- Reset asserted mid-stream → `RegWrite`=0, `A3`=0, `WD3`=0, `md_ready`=1 immediately; previously buffered entries never written.
- ALU write dst=5, value 0x1234 → next cycle `RegWrite`=1, `A3`=5, `WD3`=0x1234; same with dst=0 → `RegWrite`=0.
- `mem_rdata`=0x80FF7F01, lb at offset 3 → `WD3`=0xFFFFFF80; lbu at offset 3 → 0x00000080; lh at offset 2 → 0xFFFF80FF; with macro undefined → 0x80FF7F01.
- Push md {dst 7, 0xAAAA} during back-to-back pipeline writes → `stall_req` pulses after 4 waiting cycles, then `A3`=7, `WD3`=0xAAAA; `md_ready`=0 while 2 entries are held.
- Buffered md dst=9, then pipeline write dst=9 value 0x55 → register 9 written with 0x55 only; the md entry is never written.
